// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU codes,
// condition codes and data-processing command codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bundle: latched instruction fields and ALU flags in,
// mux selects, ALU operation and write enables out.
interface arm_mc_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       AdrSrc;
  logic [1:0] RegSrc;
  logic [1:0] ImmSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl
  );
endinterface

// File: rtl/arm_cond_unit.sv
// NZCV flag register, ARM condition evaluation, and the condition-gated
// architectural write enables.
module arm_cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       decode,
  input  logic       pc_fetch,
  input  logic       branch,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  input  logic       rd_is_pc,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags;
  logic       cond_ex;
  logic       cond_ex_r;
  logic       n, z, c, v;
  logic       wb_ok;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~(c & ~z);
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = ~(~z & (n == v));
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // The condition is frozen at DECODE so a flag update later in the same
  // instruction cannot change whether that instruction commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= RESET_FLAGS;
      cond_ex_r <= 1'b0;
    end else begin
      if (decode)
        cond_ex_r <= cond_ex;
      if (cond_ex_r && flag_w[1])
        flags[3:2] <= alu_flags[3:2];
      if (cond_ex_r && flag_w[0])
        flags[1:0] <= alu_flags[1:0];
    end
  end

  assign wb_ok     = cond_ex_r & ~no_write;
  assign reg_write = ~reset & reg_w & wb_ok;
  assign mem_write = ~reset & mem_w & cond_ex_r;
  assign pc_write  = ~reset & (pc_fetch | (branch & cond_ex_r) | (reg_w & wb_ok & rd_is_pc));

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: FSM sequencing, main decode and ALU decode;
// condition checking and write gating live in arm_cond_unit.
module arm_mc_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_mc_controller_if.master  bus
);

  state_t     state_q, state_d;
  logic [1:0] dp_alu;
  logic       dp_no_write;
  logic [1:0] dp_flag_w;
  logic       no_write;
  logic [1:0] flag_w;
  logic       ir_w;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Unsupported commands still sequence normally but never write back.
  always_comb begin
    dp_alu      = ALU_ADD;
    dp_no_write = 1'b0;
    dp_flag_w   = 2'b00;
    case (bus.Funct[4:1])
      CMD_ADD: dp_alu = ALU_ADD;
      CMD_SUB: dp_alu = ALU_SUB;
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_CMP: begin
        dp_alu      = ALU_SUB;
        dp_no_write = 1'b1;
      end
      default: dp_no_write = 1'b1;
    endcase
    if (bus.Funct[0]) begin
      case (bus.Funct[4:1])
        CMD_ADD, CMD_SUB, CMD_CMP: dp_flag_w = 2'b11;
        CMD_AND, CMD_ORR:          dp_flag_w = 2'b10;
        default:                   dp_flag_w = 2'b00;
      endcase
    end
  end

  assign no_write = (bus.Op == OP_DP) & dp_no_write;

  always_comb begin
    ir_w           = 1'b0;
    flag_w         = 2'b00;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
    bus.ImmSrc     = bus.Op;
    case (state_q)
      S_FETCH: begin
        ir_w          = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_MEMADR: bus.ALUSrcB = 2'b01;
      S_MEMRD:  bus.AdrSrc = 1'b1;
      S_MEMWB:  bus.ResultSrc = 2'b01;
      S_MEMWR:  bus.AdrSrc = 1'b1;
      S_EXECR: begin
        bus.ALUControl = dp_alu;
        flag_w         = dp_flag_w;
      end
      S_EXECI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = dp_alu;
        flag_w         = dp_flag_w;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.IRWrite = ir_w & ~reset;

  arm_cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (bus.Cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .decode    (state_q == S_DECODE),
    .pc_fetch  (state_q == S_FETCH),
    .branch    (state_q == S_BRANCH),
    .reg_w     ((state_q == S_MEMWB) || (state_q == S_ALUWB)),
    .mem_w     (state_q == S_MEMWR),
    .no_write  (no_write),
    .rd_is_pc  (bus.Rd == REG_PC),
    .pc_write  (bus.PCWrite),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite)
  );

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: directed instructions push one expected
// output vector per cycle; a negedge monitor pops and compares.
module tb_arm_mc_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  arm_mc_controller_if bus();

  arm_mc_controller #(.RESET_FLAGS(4'b0000)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                    T_EXECR, T_EXECI, T_ALUWB, T_BRANCH} st_t;

  typedef struct {
    string       tag;
    logic [15:0] vec;
    bit          chkf;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  // Packing: {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,RegSrc,ImmSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
  function automatic logic [15:0] expVec(st_t s, logic [1:0] op, logic [5:0] funct,
                                         logic [3:0] rd, bit pass, bit rst);
    logic pc, ir, mw, rw, adr, as;
    logic [1:0] bs, rs, ac, dpac;
    bit nowr;
    pc = 0; ir = 0; mw = 0; rw = 0; adr = 0; as = 0; bs = 0; rs = 0; ac = 0;
    nowr = 0;
    case (funct[4:1])
      4'b0100: dpac = 2'b00;
      4'b0010: dpac = 2'b01;
      4'b0000: dpac = 2'b10;
      4'b1100: dpac = 2'b11;
      4'b1010: begin dpac = 2'b01; nowr = 1; end
      default: begin dpac = 2'b00; nowr = 1; end
    endcase
    case (s)
      T_FETCH:  begin ir = 1; as = 1; bs = 2'b10; rs = 2'b10; pc = 1; end
      T_DECODE: begin as = 1; bs = 2'b10; rs = 2'b10; end
      T_MEMADR: bs = 2'b01;
      T_MEMRD:  adr = 1;
      T_MEMWB:  begin rs = 2'b01; rw = pass; pc = pass && (rd == 4'd15); end
      T_MEMWR:  begin adr = 1; mw = pass; end
      T_EXECR:  ac = dpac;
      T_EXECI:  begin bs = 2'b01; ac = dpac; end
      T_ALUWB:  begin rw = pass && !nowr; pc = pass && !nowr && (rd == 4'd15); end
      T_BRANCH: begin bs = 2'b01; rs = 2'b10; pc = pass; end
      default: ;
    endcase
    if (rst) begin pc = 0; ir = 0; mw = 0; rw = 0; end
    return {pc, ir, mw, rw, adr, op == 2'b01, op == 2'b10, op, as, bs, rs, ac};
  endfunction

  // Drives one cycle of inputs and queues what the DUT must show in that cycle.
  task automatic applyStimulus(string tag, logic [3:0] cond, logic [1:0] op,
                               logic [5:0] funct, logic [3:0] rd, logic [3:0] aluf,
                               st_t s, bit pass, bit rst, bit chkf, logic [3:0] efl);
    exp_t e;
    reset        = rst;
    bus.Cond     = cond;
    bus.Op       = op;
    bus.Funct    = funct;
    bus.Rd       = rd;
    bus.ALUFlags = aluf;
    e.tag  = $sformatf("%s/%s", tag, s.name());
    e.vec  = expVec(s, op, funct, rd, pass, rst);
    e.chkf = chkf;
    e.flg  = efl;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Walks one whole instruction; flags are checked in its last cycle.
  task automatic runInstr(string tag, logic [3:0] cond, logic [1:0] op, logic [5:0] funct,
                          logic [3:0] rd, logic [3:0] aluf, bit pass, logic [3:0] efl);
    st_t seq[$];
    seq = {T_FETCH, T_DECODE};
    case (op)
      2'b01: begin
        seq.push_back(T_MEMADR);
        if (funct[0]) begin seq.push_back(T_MEMRD); seq.push_back(T_MEMWB); end
        else seq.push_back(T_MEMWR);
      end
      2'b00: begin
        seq.push_back(funct[5] ? T_EXECI : T_EXECR);
        seq.push_back(T_ALUWB);
      end
      2'b10: seq.push_back(T_BRANCH);
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++)
      applyStimulus(tag, cond, op, funct, rd, aluf, seq[i], pass, 1'b0,
                    i == seq.size() - 1, efl);
  endtask

  task automatic checkOutput(exp_t e);
    logic [15:0] act;
    act = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.AdrSrc,
           bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
    compared++;
    if (act !== e.vec) begin
      mismatched++;
      $display("[TB] FAIL %s outputs: got %b required %b", e.tag, act, e.vec);
    end
    if (e.chkf) begin
      compared++;
      if (u_dut.u_cond.flags !== e.flg) begin
        mismatched++;
        $display("[TB] FAIL %s flags: got %b required %b", e.tag, u_dut.u_cond.flags, e.flg);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    bus.Cond = 4'he; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("reset", 4'he, 2'b00, 6'd0, 4'd0, 4'd0, T_FETCH, 1'b0, 1'b1, 1'b1, 4'b0000);

    runInstr("add",      4'b1110, 2'b00, 6'b001000, 4'd1,  4'b0000, 1'b1, 4'b0000);
    runInstr("cmp_z",    4'b1110, 2'b00, 6'b010101, 4'd0,  4'b0100, 1'b1, 4'b0100);
    runInstr("beq_take", 4'b0000, 2'b10, 6'b000000, 4'd0,  4'b0000, 1'b1, 4'b0100);
    runInstr("cmp_nz",   4'b1110, 2'b00, 6'b010101, 4'd0,  4'b0000, 1'b1, 4'b0000);
    runInstr("beq_skip", 4'b0000, 2'b10, 6'b000000, 4'd0,  4'b0000, 1'b0, 4'b0000);
    runInstr("ldr",      4'b1110, 2'b01, 6'b011001, 4'd2,  4'b0000, 1'b1, 4'b0000);
    runInstr("ldr_pc",   4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 1'b1, 4'b0000);
    runInstr("cmp_z2",   4'b1110, 2'b00, 6'b010101, 4'd0,  4'b0100, 1'b1, 4'b0100);
    runInstr("strne_no", 4'b0001, 2'b01, 6'b011000, 4'd3,  4'b0000, 1'b0, 4'b0100);
    runInstr("cmp_nz2",  4'b1110, 2'b00, 6'b010101, 4'd0,  4'b0000, 1'b1, 4'b0000);
    runInstr("strne_go", 4'b0001, 2'b01, 6'b011000, 4'd3,  4'b0000, 1'b1, 4'b0000);
    runInstr("cmp_0110", 4'b1110, 2'b00, 6'b010101, 4'd0,  4'b0110, 1'b1, 4'b0110);
    runInstr("ands",     4'b1110, 2'b00, 6'b000001, 4'd3,  4'b1001, 1'b1, 4'b1010);
    runInstr("subseq_i", 4'b0000, 2'b00, 6'b100101, 4'd4,  4'b0101, 1'b0, 4'b1010);
    runInstr("orr_pc",   4'b1110, 2'b00, 6'b011000, 4'd15, 4'b0000, 1'b1, 4'b1010);
    runInstr("eor_nw",   4'b1110, 2'b00, 6'b000010, 4'd5,  4'b0000, 1'b1, 4'b1010);

    applyStimulus("str_rst", 4'b1110, 2'b01, 6'b011000, 4'd4, 4'd0, T_FETCH,  1'b1, 1'b0, 1'b0, 4'b0);
    applyStimulus("str_rst", 4'b1110, 2'b01, 6'b011000, 4'd4, 4'd0, T_DECODE, 1'b1, 1'b0, 1'b0, 4'b0);
    applyStimulus("str_rst", 4'b1110, 2'b01, 6'b011000, 4'd4, 4'd0, T_MEMADR, 1'b1, 1'b0, 1'b1, 4'b1010);
    applyStimulus("str_rst", 4'b1110, 2'b01, 6'b011000, 4'd4, 4'd0, T_MEMWR,  1'b1, 1'b1, 1'b0, 4'b0);

    runInstr("undef",    4'b1110, 2'b11, 6'b000000, 4'd6,  4'b0000, 1'b1, 4'b0000);
    runInstr("add_end",  4'b1110, 2'b00, 6'b001000, 4'd7,  4'b0000, 1'b1, 4'b0000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
